// File: rtl/flash_boot_loader_pkg.sv
// Boot copy address map, segment descriptor type and sequencer state encoding
// shared by the flash-to-SDRAM boot loader.
package flash_boot_loader_pkg;

   localparam logic [23:0] FLASH_ADDR_BIOS      = 24'h10_0000;
   localparam logic [23:0] FLASH_ADDR_MEGAROM   = 24'h20_0000;
   localparam logic [23:0] RAM_ADDR_BIOS_NEXTOR = 24'h70_0000;
   localparam logic [23:0] RAM_ADDR_MEGAROM     = 24'h40_0000;
   localparam logic [23:0] FLASH_SIZE_BIOS      = 24'h02_4000;
   localparam logic [23:0] FLASH_SIZE_MEGAROM   = 24'h10_0000;
   localparam logic        ENABLE_MEGAROM       = 1'b1;
   localparam int          BOOT_SEG_COUNT       = 2;

   typedef struct packed {
      logic [23:0] flash_addr;
      logic [23:0] ram_addr;
      logic [23:0] size;
   } boot_seg_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEL  = 2'd1,
      ST_RUN  = 2'd2,
      ST_FIN  = 2'd3
   } boot_state_t;

   // Odd sizes are truncated: the copy engine only moves whole 16-bit words.
   function automatic logic [22:0] seg_words(input boot_seg_t seg);
      return seg.size[23:1];
   endfunction

endpackage

// File: rtl/flash_boot_loader_fifo.sv
// Two-entry, 16-bit buffer decoupling flash reads from SDRAM writes;
// asynchronously cleared so no stale word survives a reset.
module boot_copy_fifo (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [15:0] din,
   input  logic        pop,
   output logic [1:0]  count,
   output logic [15:0] head
);

   logic [15:0] mem_r [2];
   logic        wr_ptr_r;
   logic        rd_ptr_r;
   logic [1:0]  count_r;
   logic        pop_ok_s;
   logic        push_ok_s;

   assign pop_ok_s  = pop & (count_r != 2'd0);
   assign push_ok_s = push & ((count_r != 2'd2) | pop_ok_s);

   // Storage, pointers and occupancy; simultaneous push/pop keeps occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_r[0] <= 16'h0000;
         mem_r[1] <= 16'h0000;
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
      end
   end

   assign count = count_r;
   assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/flash_boot_loader.sv
// Boot-time sequencer copying the BIOS and MegaROM images from serial flash
// into SDRAM, holding busy until the final word is written.
module flash_boot_loader
   import flash_boot_loader_pkg::*;
#(
   parameter logic [23:0] BIOS_SIZE    = FLASH_SIZE_BIOS,
   parameter logic [23:0] MEGAROM_SIZE = ENABLE_MEGAROM ? FLASH_SIZE_MEGAROM : 24'h00_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        flash_req,
   output logic [23:0] flash_addr,
   input  logic        flash_ack,
   input  logic [15:0] flash_data,
   output logic        ram_req,
   output logic [23:0] ram_addr,
   output logic [15:0] ram_wdata,
   input  logic        ram_ack,
   output logic        busy,
   output logic        done
);

   boot_state_t state_r, state_nxt_s;
   boot_seg_t   seg_table_s [BOOT_SEG_COUNT];
   boot_seg_t   sel_seg_s;
   logic [1:0]  seg_idx_r;
   logic        sel_found_s;
   logic        sel_idx_s;
   logic [22:0] rd_cnt_r, wr_cnt_r, rd_cnt_nxt_s, wr_cnt_nxt_s;
   logic [23:0] flash_addr_r, ram_addr_r;
   logic        flash_req_r, busy_r, done_r;
   logic        flash_req_nxt_s, busy_nxt_s, done_nxt_s;
   logic        push_s, pop_s;
   logic [1:0]  fifo_count_s, count_nxt_s;
   logic [15:0] fifo_head_s;

   assign seg_table_s[0] = '{flash_addr: FLASH_ADDR_BIOS, ram_addr: RAM_ADDR_BIOS_NEXTOR, size: BIOS_SIZE};
   assign seg_table_s[1] = '{flash_addr: FLASH_ADDR_MEGAROM, ram_addr: RAM_ADDR_MEGAROM, size: MEGAROM_SIZE};

   boot_copy_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .din   (flash_data),
      .pop   (pop_s),
      .count (fifo_count_s),
      .head  (fifo_head_s)
   );

   // ACKs only count while the matching request is raised.
   assign push_s       = flash_req_r & flash_ack;
   assign pop_s        = ram_req & ram_ack;
   assign rd_cnt_nxt_s = rd_cnt_r - {22'd0, push_s};
   assign wr_cnt_nxt_s = wr_cnt_r - {22'd0, pop_s};
   assign count_nxt_s  = fifo_count_s + {1'b0, push_s} - {1'b0, pop_s};

   // First remaining non-empty segment at or after the current index.
   always_comb begin
      sel_found_s = 1'b0;
      sel_idx_s   = 1'b0;
      for (int i = BOOT_SEG_COUNT - 1; i >= 0; i--) begin
         sel_found_s = sel_found_s | ((2'(i) >= seg_idx_r) && (seg_words(seg_table_s[i]) != 23'd0));
         sel_idx_s   = ((2'(i) >= seg_idx_r) && (seg_words(seg_table_s[i]) != 23'd0)) ? 1'(i) : sel_idx_s;
      end
      sel_seg_s = seg_table_s[sel_idx_s];
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; a segment ends only on its last RAM write.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: state_nxt_s = ST_SEL;
         ST_SEL:  state_nxt_s = sel_found_s ? ST_RUN : ST_FIN;
         ST_RUN:  state_nxt_s = (wr_cnt_nxt_s == 23'd0) ? ST_SEL : ST_RUN;
         ST_FIN:  state_nxt_s = ST_FIN;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode; a read is only issued if its word will have a free slot.
   always_comb begin
      flash_req_nxt_s = 1'b0;
      case (state_r)
         ST_SEL:  flash_req_nxt_s = sel_found_s;
         ST_RUN:  flash_req_nxt_s = (rd_cnt_nxt_s != 23'd0) && (count_nxt_s <= 2'd1);
         default: flash_req_nxt_s = 1'b0;
      endcase
      busy_nxt_s = (state_nxt_s == ST_SEL) || (state_nxt_s == ST_RUN);
      done_nxt_s = (state_nxt_s == ST_FIN);
   end

   // Segment load, word counters, address registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_idx_r    <= 2'd0;
         rd_cnt_r     <= 23'd0;
         wr_cnt_r     <= 23'd0;
         flash_addr_r <= 24'h00_0000;
         ram_addr_r   <= 24'h00_0000;
         flash_req_r  <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         flash_req_r <= flash_req_nxt_s;
         busy_r      <= busy_nxt_s;
         done_r      <= done_nxt_s;
         if ((state_r == ST_SEL) && sel_found_s) begin
            seg_idx_r    <= {1'b0, sel_idx_s} + 2'd1;
            rd_cnt_r     <= seg_words(sel_seg_s);
            wr_cnt_r     <= seg_words(sel_seg_s);
            flash_addr_r <= sel_seg_s.flash_addr;
            ram_addr_r   <= sel_seg_s.ram_addr;
         end else begin
            rd_cnt_r     <= rd_cnt_nxt_s;
            wr_cnt_r     <= wr_cnt_nxt_s;
            flash_addr_r <= flash_addr_r + (push_s ? 24'd2 : 24'd0);
            ram_addr_r   <= ram_addr_r + (pop_s ? 24'd2 : 24'd0);
         end
      end
   end

   assign flash_req  = flash_req_r;
   assign flash_addr = flash_addr_r;
   assign ram_req    = (fifo_count_s != 2'd0);
   assign ram_addr   = ram_addr_r;
   assign ram_wdata  = fifo_head_s;
   assign busy       = busy_r;
   assign done       = done_r;

endmodule
